pipeline_sequencer: RTL

//  Owns the fetch PC register and issues the per-stage stall/flush strobes for the 5-stage core.

---
 rtl/pipeline_sequencer_if.sv | 29 ++
 rtl/pipeline_sequencer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pipeline_sequencer_if.sv
// Control bundle between the pipeline sequencer and the flow controller, hazard unit,
// debug port and IF stage.
interface pipeline_sequencer_if;
  logic        redirect_i;
  logic [31:0] redirect_target_i;
  logic        flush_req_i;
  logic        load_use_i;
  logic        halt_req_i;
  logic        resume_req_i;
  logic        step_req_i;
  logic [31:0] pc_o;
  logic        fetch_valid_o;
  logic        if_id_stall_o;
  logic        if_id_flush_o;
  logic        id_ex_flush_o;
  logic        halted_o;

  modport master (
    input  redirect_i, redirect_target_i, flush_req_i, load_use_i,
    input  halt_req_i, resume_req_i, step_req_i,
    output pc_o, fetch_valid_o, if_id_stall_o, if_id_flush_o, id_ex_flush_o, halted_o
  );

  modport slave (
    output redirect_i, redirect_target_i, flush_req_i, load_use_i,
    output halt_req_i, resume_req_i, step_req_i,
    input  pc_o, fetch_valid_o, if_id_stall_o, if_id_flush_o, id_ex_flush_o, halted_o
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// Fetch PC owner and stall/flush strobe generator for the 5-stage core, arbitrating
// redirects, load-use stalls and debug halt/step/resume.
module pipeline_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned DRAIN_CYCLES = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  pipeline_sequencer_if.master bus
);

  localparam int unsigned      CNT_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DRAIN_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_HALTED = 2'd2,
    ST_STEP   = 2'd3
  } state_e;

  state_e             state_r, state_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic [31:0]        pc_r, pc_s;
  logic               halted_r;
  logic               redirect_s;
  logic [31:0]        target_s;
  logic               fetch_valid_s;
  logic               if_id_stall_s;
  logic               if_id_flush_s;
  logic               id_ex_flush_s;

  // Next-state, next-PC and same-cycle strobe decode
  always_comb begin
    state_s       = state_r;
    cnt_s         = cnt_r;
    pc_s          = pc_r;
    fetch_valid_s = 1'b0;
    if_id_stall_s = 1'b0;
    if_id_flush_s = 1'b0;
    id_ex_flush_s = 1'b0;
    redirect_s    = bus.redirect_i | bus.flush_req_i;
    target_s      = {bus.redirect_target_i[31:1], 1'b0};

    // A redirect overrides any stall and flushes both front-end registers in every state
    if (redirect_s) begin
      if_id_flush_s = 1'b1;
      id_ex_flush_s = 1'b1;
      pc_s          = target_s;
    end else begin
      if_id_flush_s = 1'b0;
    end

    case (state_r)
      ST_RUN: begin
        fetch_valid_s = ~bus.load_use_i;
        if (redirect_s) begin
          pc_s = target_s;
        end else if (bus.load_use_i) begin
          if_id_stall_s = 1'b1;
          id_ex_flush_s = 1'b1;
        end else begin
          pc_s = pc_r + 32'd4;
        end
        if (bus.halt_req_i) begin
          state_s = ST_DRAIN;
          cnt_s   = CNT_LOAD;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (!redirect_s && bus.load_use_i) begin
          if_id_stall_s = 1'b1;
          id_ex_flush_s = 1'b1;
        end else begin
          if_id_stall_s = 1'b0;
        end
        if (cnt_r == {CNT_W{1'b0}}) begin
          state_s = ST_HALTED;
        end else begin
          cnt_s = cnt_r - CNT_W'(1);
        end
      end
      ST_HALTED: begin
        if (bus.resume_req_i) begin
          state_s = ST_RUN;
        end else if (bus.step_req_i) begin
          state_s = ST_STEP;
        end else begin
          state_s = ST_HALTED;
        end
      end
      ST_STEP: begin
        fetch_valid_s = ~bus.load_use_i;
        // A redirect consumes the step; a load-use stall retries it next cycle
        if (redirect_s) begin
          state_s = ST_DRAIN;
          cnt_s   = CNT_LOAD;
        end else if (bus.load_use_i) begin
          if_id_stall_s = 1'b1;
          id_ex_flush_s = 1'b1;
        end else begin
          pc_s    = pc_r + 32'd4;
          state_s = ST_DRAIN;
          cnt_s   = CNT_LOAD;
        end
      end
      default: begin
        state_s = ST_RUN;
      end
    endcase
  end

  // State, drain counter, PC and halted flag registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= ST_RUN;
      cnt_r    <= {CNT_W{1'b0}};
      pc_r     <= RESET_PC;
      halted_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      cnt_r    <= cnt_s;
      pc_r     <= pc_s;
      halted_r <= (state_s == ST_HALTED);
    end
  end

  assign bus.pc_o          = pc_r;
  assign bus.halted_o      = halted_r;
  assign bus.fetch_valid_o = rst_ni & fetch_valid_s;
  assign bus.if_id_stall_o = rst_ni & if_id_stall_s;
  assign bus.if_id_flush_o = rst_ni & if_id_flush_s;
  assign bus.id_ex_flush_o = rst_ni & id_ex_flush_s;

endmodule
